// File: rtl/bus_cycle_ctrl_if.sv
// rtl/bus_cycle_ctrl_if.sv - 68000 bus cycle strobes, MMU result and glue outputs
interface bus_cycle_ctrl_if;
   logic       as_n;
   logic       uds_n;
   logic       lds_n;
   logic       read;
   logic [2:0] fc;
   logic       xlate_valid;
   logic       xlate_fault;
   logic       sel_rom;
   logic       sel_ram;
   logic       dtack_n;
   logic       berr_n;
   logic       rom_enable_n;
   logic       ram_enable_n;
   logic       busy;

   modport master (
      output as_n, uds_n, lds_n, read, fc,
      output xlate_valid, xlate_fault, sel_rom, sel_ram,
      input  dtack_n, berr_n, rom_enable_n, ram_enable_n, busy
   );

   modport slave (
      input  as_n, uds_n, lds_n, read, fc,
      input  xlate_valid, xlate_fault, sel_rom, sel_ram,
      output dtack_n, berr_n, rom_enable_n, ram_enable_n, busy
   );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - 68000 bus cycle sequencer: MMU wait, chip enables, wait states, DTACK/BERR
// Optional watchdog on stalled XLATE/WAIT cycles enabled by BUS_CYCLE_WATCHDOG_EN.
module bus_cycle_ctrl #(
   parameter int unsigned ROM_WAIT = 2,
   parameter int unsigned RAM_WAIT = 1,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic            clk,
   input  logic            reset_n,
   bus_cycle_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, XLATE, WAIT, ACK, FAULT} state_t;

   if (ROM_WAIT > 15 || RAM_WAIT > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
      $error("bus_cycle_ctrl: parameter out of range");
   end

   state_t     state, state_nx;
   logic [3:0] count, count_nx;
   logic       dtack_q, berr_q, rom_q, ram_q, busy_q;
   logic       dtack_nx, berr_nx, rom_nx, ram_nx;
   logic       timeout_hit;

   // Data strobes do not qualify the cycle: strobe-less RMW address phases are accepted.
   logic unused_strobes;
   assign unused_strobes = &{1'b0, bus.uds_n, bus.lds_n};

`ifdef BUS_CYCLE_WATCHDOG_EN
   logic [7:0] timer;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer <= '0;
      end else if (state == IDLE) begin
         timer <= '0;
      end else if (state == XLATE || state == WAIT) begin
         timer <= timer + 8'd1;
      end
   end

   assign timeout_hit = (timer == 8'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         count   <= '0;
         dtack_q <= 1'b1;
         berr_q  <= 1'b1;
         rom_q   <= 1'b1;
         ram_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         dtack_q <= dtack_nx;
         berr_q  <= berr_nx;
         rom_q   <= rom_nx;
         ram_q   <= ram_nx;
         busy_q  <= (state_nx != IDLE);
      end
   end

   always_comb begin
      state_nx = state;
      count_nx = count;
      rom_nx   = 1'b1;
      ram_nx   = 1'b1;
      case (state)
         IDLE: begin
            if (!bus.as_n) begin
               state_nx = (bus.fc == 3'b111) ? FAULT : XLATE;
            end
         end
         XLATE: begin
            // Abort outranks the watchdog, which outranks the MMU result.
            if (bus.as_n) begin
               state_nx = IDLE;
            end else if (timeout_hit) begin
               state_nx = FAULT;
            end else if (bus.xlate_valid) begin
               if (bus.xlate_fault) begin
                  state_nx = FAULT;
               end else if (bus.sel_rom) begin
                  if (!bus.read) begin
                     state_nx = FAULT;
                  end else begin
                     state_nx = WAIT;
                     count_nx = 4'(ROM_WAIT);
                     rom_nx   = 1'b0;
                  end
               end else if (bus.sel_ram) begin
                  state_nx = WAIT;
                  count_nx = 4'(RAM_WAIT);
                  ram_nx   = 1'b0;
               end else begin
                  state_nx = FAULT;
               end
            end
         end
         WAIT: begin
            if (bus.as_n) begin
               state_nx = IDLE;
            end else if (timeout_hit) begin
               state_nx = FAULT;
            end else begin
               rom_nx = rom_q;
               ram_nx = ram_q;
               if (count == 4'd0) begin
                  state_nx = ACK;
               end else begin
                  count_nx = count - 4'd1;
               end
            end
         end
         ACK: begin
            if (bus.as_n) begin
               state_nx = IDLE;
            end else begin
               rom_nx = rom_q;
               ram_nx = ram_q;
            end
         end
         FAULT: begin
            if (bus.as_n) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      dtack_nx = (state_nx != ACK);
      berr_nx  = (state_nx != FAULT);
   end

   assign bus.dtack_n      = dtack_q;
   assign bus.berr_n       = berr_q;
   assign bus.rom_enable_n = rom_q;
   assign bus.ram_enable_n = ram_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - self-checking bench for bus_cycle_ctrl against a cycle-timeline model
module tb_bus_cycle_ctrl;
   localparam int ROM_W   = 2;
   localparam int RAM_W   = 0;
   localparam int TB_TOUT = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   passed = 0;

   // Transaction description: as_n low for edges 0..t_l-1, xlate_valid from edge t_d.
   logic [2:0] t_fc;
   logic       t_read, t_rom, t_ram, t_fault;
   int         t_d, t_l;

   bus_cycle_ctrl_if bus ();

   bus_cycle_ctrl #(.ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .TIMEOUT(TB_TOUT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Expected {busy, dtack_n, berr_n, rom_enable_n, ram_enable_n} just after edge k.
   function automatic logic [4:0] expect_at(input int k);
      logic busy_e, dtack_e, berr_e, rom_e, ram_e;
      bit   ok_rom, ok_ram;
      int   n;
      ok_rom  = !t_fault && t_rom && t_read;
      ok_ram  = !t_fault && !t_rom && t_ram;
      n       = ok_rom ? ROM_W : RAM_W;
      busy_e  = 1'b0;
      dtack_e = 1'b1;
      berr_e  = 1'b1;
      rom_e   = 1'b1;
      ram_e   = 1'b1;
      if (k < t_l) begin
         busy_e = 1'b1;
         if (t_fc == 3'd7) begin
            berr_e = 1'b0;
         end else if (k >= t_d) begin
            if (ok_rom) rom_e = 1'b0;
            else if (ok_ram) ram_e = 1'b0;
            else berr_e = 1'b0;
            if ((ok_rom || ok_ram) && k > t_d + n) dtack_e = 1'b0;
         end
`ifdef BUS_CYCLE_WATCHDOG_EN
         if (t_fc != 3'd7 && k >= TB_TOUT &&
             (t_d >= TB_TOUT || ((ok_rom || ok_ram) && t_d + n + 1 >= TB_TOUT))) begin
            dtack_e = 1'b1;
            berr_e  = 1'b0;
            rom_e   = 1'b1;
            ram_e   = 1'b1;
         end
`endif
      end
      return {busy_e, dtack_e, berr_e, rom_e, ram_e};
   endfunction

   task automatic check(input string tag, input int k, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {bus.busy, bus.dtack_n, bus.berr_n, bus.rom_enable_n, bus.ram_enable_n};
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s edge=%0d observed(busy,dtack_n,berr_n,rom_n,ram_n)=%b expected=%b",
                  tag, k, obs, exp);
      total++;
      assert (!(obs[3] === 1'b0 && obs[2] === 1'b0)) passed++;
      else $error("FAIL %s_excl edge=%0d observed dtack_n=%b berr_n=%b expected not both 0",
                  tag, k, obs[3], obs[2]);
   endtask

   // Called at a falling edge; drives then checks edges 0..last.
   task automatic run_txn(input string tag, input int last);
      for (int k = 0; k <= last; k++) begin
         bus.as_n        = (k >= t_l);
         bus.uds_n       = 1'($urandom_range(0, 1));
         bus.lds_n       = 1'($urandom_range(0, 1));
         bus.read        = t_read;
         bus.fc          = t_fc;
         bus.xlate_valid = (k >= t_d);
         if (k >= t_d) begin
            bus.xlate_fault = t_fault;
            bus.sel_rom     = t_rom;
            bus.sel_ram     = t_ram;
         end else begin
            bus.xlate_fault = 1'($urandom_range(0, 1));
            bus.sel_rom     = 1'($urandom_range(0, 1));
            bus.sel_ram     = 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         @(negedge clk);
         check(tag, k, expect_at(k));
      end
   endtask

   task automatic set_txn(input logic [2:0] fc, input logic rd, input logic rom, input logic ram,
                          input logic flt, input int d, input int l);
      t_fc = fc; t_read = rd; t_rom = rom; t_ram = ram; t_fault = flt; t_d = d; t_l = l;
   endtask

   initial begin
      bus.as_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1; bus.read = 1'b1; bus.fc = 3'd0;
      bus.xlate_valid = 1'b0; bus.xlate_fault = 1'b0; bus.sel_rom = 1'b0; bus.sel_ram = 1'b0;
      repeat (2) @(negedge clk);
      check("reset", 0, 5'b01111);
      reset_n = 1'b1;

      set_txn(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1, 7);    run_txn("rom_read", 8);
      set_txn(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 4);    run_txn("ram_write", 5);
      set_txn(3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1, 5);    run_txn("rom_write", 6);
      set_txn(3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3, 6);    run_txn("mmu_fault", 7);
      set_txn(3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1, 3);    run_txn("cpu_space", 4);
      set_txn(3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2, 7);    run_txn("rom_wins", 8);
      set_txn(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 4);    run_txn("no_select", 5);
      set_txn(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2);    run_txn("abort_wait", 3);
      set_txn(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1000, 100); run_txn("no_valid", 101);

      for (int i = 0; i < 40; i++) begin
         set_txn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                 int'($urandom_range(1, 4)), int'($urandom_range(1, 12)));
         run_txn("random", t_l + 1);
      end

      set_txn(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1, 10);   run_txn("pre_reset", 5);
      reset_n = 1'b0;
      #1;
      check("reset_in_ack", 0, 5'b01111);
      bus.as_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_hold", 1, 5'b01111);
      reset_n = 1'b1;
      set_txn(3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 4);    run_txn("after_reset", 5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
